uart_rx_drain_arb: RTL and testbench

UART_RX_DRAIN_ARB -- requirements
Module: uart_rx_drain_arb

---
 rtl/uart_rx_drain_arb.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_drain_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_drain_arb.sv
// Purpose : drains an FWFT RX FIFO to either a CPU register read or a byte stream, plus an optional idle-timeout IRQ.
// Latency : the FIFO pop is combinational in the grant cycle; the CPU response and stream valid follow one cycle later.
// Backpr. : the stream byte is held until i_m_ready; CPU requests that arrive while busy park in a 1-deep pend (further ones drop).
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   i_fifo_empty, i_fifo_rd_data  FWFT FIFO status and head byte
//   o_fifo_rd_en                  FIFO pop (combinational)
//   i_fifo_wr_en                  receiver write pulse (restarts the timeout only)
//   i_cpu_rd_req                  CPU read strobe
//   o_cpu_rd_valid/_data/_empty   one-cycle CPU read response
//   i_stream_en                   allows stream draining
//   o_m_valid, o_m_data, i_m_ready  stream master handshake
//   i_timeout, i_irq_clr          idle threshold (0 = off) and IRQ clear
//   o_irq_timeout                 sticky character-timeout interrupt
//
// Optional feature: define UART_RX_DRAIN_TIMEOUT_EN to build the timeout
// counter. Without it, o_irq_timeout is tied low.
module uart_rx_drain_arb #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_fifo_empty,
  input  logic [7:0]       i_fifo_rd_data,
  output logic             o_fifo_rd_en,
  input  logic             i_fifo_wr_en,
  input  logic             i_cpu_rd_req,
  output logic             o_cpu_rd_valid,
  output logic [7:0]       o_cpu_rd_data,
  output logic             o_cpu_rd_empty,
  input  logic             i_stream_en,
  output logic             o_m_valid,
  output logic [7:0]       o_m_data,
  input  logic             i_m_ready,
  input  logic [TMO_W-1:0] i_timeout,
  input  logic             i_irq_clr,
  output logic             o_irq_timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_RESP  = 2'd1,
    STRM_HOLD = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       pend;         // one parked CPU request
  logic       last_cpu;     // round-robin pointer: 1 means the CPU won last
  logic [7:0] cpu_byte;
  logic       cpu_empty;
  logic [7:0] m_byte;

  logic       cpu_pending;
  logic       strm_elig;
  logic       grant_cpu;
  logic       grant_strm;
  logic       pop;

  // Grant decision. Only made in IDLE and never while reset is asserted,
  // so reset can never pop the FIFO.
  always_comb begin
    cpu_pending = i_cpu_rd_req | pend;
    strm_elig   = i_stream_en & ~i_fifo_empty;
    grant_cpu   = 1'b0;
    grant_strm  = 1'b0;
    if (rst_n && (state == IDLE)) begin
      if (cpu_pending && strm_elig) begin
        grant_cpu  = ~last_cpu;
        grant_strm = last_cpu;
      end else begin
        grant_cpu  = cpu_pending;
        grant_strm = strm_elig;
      end
    end
    pop = (grant_cpu & ~i_fifo_empty) | grant_strm;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_cpu)       state_nxt = CPU_RESP;
        else if (grant_strm) state_nxt = STRM_HOLD;
      end
      CPU_RESP:  state_nxt = IDLE;
      STRM_HOLD: if (i_m_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs. Data fields are gated by their strobes so the bus idles at zero.
  always_comb begin
    o_fifo_rd_en   = pop;
    o_cpu_rd_valid = rst_n && (state == CPU_RESP);
    o_cpu_rd_data  = o_cpu_rd_valid ? cpu_byte : 8'h00;
    o_cpu_rd_empty = o_cpu_rd_valid & cpu_empty;
    o_m_valid      = rst_n && (state == STRM_HOLD);
    o_m_data       = o_m_valid ? m_byte : 8'h00;
  end

  // Pend, round-robin pointer and captured bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      last_cpu  <= 1'b0;
      cpu_byte  <= 8'h00;
      cpu_empty <= 1'b0;
      m_byte    <= 8'h00;
    end else begin
      // A live request that is not granted this cycle is parked; one that
      // arrives while something is already parked merges into it.
      if (grant_cpu)         pend <= 1'b0;
      else if (i_cpu_rd_req) pend <= 1'b1;

      if (grant_cpu)       last_cpu <= 1'b1;
      else if (grant_strm) last_cpu <= 1'b0;

      if (grant_cpu) begin
        cpu_byte  <= i_fifo_empty ? 8'h00 : i_fifo_rd_data;
        cpu_empty <= i_fifo_empty;
      end

      if (grant_strm) m_byte <= i_fifo_rd_data;
    end
  end

`ifdef UART_RX_DRAIN_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             irq;

  // Counts idle cycles while data sits unread; any FIFO activity or an
  // empty FIFO restarts it. It saturates so a long idle cannot wrap into
  // a second match.
  always_ff @(posedge clk) begin
    if (!rst_n)                                tmo_cnt <= '0;
    else if (pop || i_fifo_wr_en || i_fifo_empty) tmo_cnt <= '0;
    else if (tmo_cnt != '1)                    tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign tmo_hit = (i_timeout != '0) && (tmo_cnt == i_timeout);

  // Set has priority over clear.
  always_ff @(posedge clk) begin
    if (!rst_n)                 irq <= 1'b0;
    else if (tmo_hit)           irq <= 1'b1;
    else if (i_irq_clr || pop)  irq <= 1'b0;
  end

  assign o_irq_timeout = irq & rst_n;
`else
  logic unused_tmo;
  assign unused_tmo    = ^{i_timeout, i_irq_clr, i_fifo_wr_en};
  assign o_irq_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_drain_arb.sv
module tb_uart_rx_drain_arb;

  localparam int TMO_W = 16;

`ifdef UART_RX_DRAIN_TIMEOUT_EN
  localparam logic TMO_ON = 1'b1;
`else
  localparam logic TMO_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_fifo_empty;
  logic [7:0]       i_fifo_rd_data;
  logic             o_fifo_rd_en;
  logic             i_fifo_wr_en;
  logic             i_cpu_rd_req;
  logic             o_cpu_rd_valid;
  logic [7:0]       o_cpu_rd_data;
  logic             o_cpu_rd_empty;
  logic             i_stream_en;
  logic             o_m_valid;
  logic [7:0]       o_m_data;
  logic             i_m_ready;
  logic [TMO_W-1:0] i_timeout;
  logic             i_irq_clr;
  logic             o_irq_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_drain_arb #(.TMO_W(TMO_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_fifo_empty   (i_fifo_empty),
    .i_fifo_rd_data (i_fifo_rd_data),
    .o_fifo_rd_en   (o_fifo_rd_en),
    .i_fifo_wr_en   (i_fifo_wr_en),
    .i_cpu_rd_req   (i_cpu_rd_req),
    .o_cpu_rd_valid (o_cpu_rd_valid),
    .o_cpu_rd_data  (o_cpu_rd_data),
    .o_cpu_rd_empty (o_cpu_rd_empty),
    .i_stream_en    (i_stream_en),
    .o_m_valid      (o_m_valid),
    .o_m_data       (o_m_data),
    .i_m_ready      (i_m_ready),
    .i_timeout      (i_timeout),
    .i_irq_clr      (i_irq_clr),
    .o_irq_timeout  (o_irq_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       empty;
    logic [7:0] data;
    logic       req;
    logic       sen;
    logic       rdy;
    logic       rd_en;
    logic       cv;
    logic [7:0] cd;
    logic       ce;
    logic       mv;
    logic [7:0] md;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic empty, logic [7:0] data, logic req, logic sen, logic rdy,
                              logic rd_en, logic cv, logic [7:0] cd, logic ce, logic mv,
                              logic [7:0] md);
    vec_t v;
    v.empty = empty; v.data = data; v.req = req; v.sen = sen; v.rdy = rdy;
    v.rd_en = rd_en; v.cv = cv; v.cd = cd; v.ce = ce; v.mv = mv; v.md = md;
    return v;
  endfunction

  // Packed view of all outputs: {rd_en, cv, cd, ce, mv, md, irq}.
  function automatic logic [20:0] pk(logic rd_en, logic cv, logic [7:0] cd, logic ce,
                                     logic mv, logic [7:0] md, logic irq);
    return {rd_en, cv, cd, ce, mv, md, irq};
  endfunction

  function automatic logic [20:0] outs();
    return {o_fifo_rd_en, o_cpu_rd_valid, o_cpu_rd_data, o_cpu_rd_empty,
            o_m_valid, o_m_data, o_irq_timeout};
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (rd_en,cv,cd,ce,mv,md,irq)", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Inputs are applied just after a falling edge and sampled 1 time unit later.
  task automatic drive(input logic empty, input logic [7:0] data, input logic req,
                       input logic sen, input logic rdy);
    i_fifo_empty   = empty;
    i_fifo_rd_data = data;
    i_cpu_rd_req   = req;
    i_stream_en    = sen;
    i_m_ready      = rdy;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One-cycle reset while offering a CPU request and a non-empty FIFO:
  // nothing may pop and every output must be 0.
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    drive(1'b0, 8'hEE, 1'b1, 1'b1, 1'b0);
    check(name, outs(), pk(0, 0, 8'h00, 0, 0, 8'h00, 0));
    tick();
    rst_n = 1'b1;
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0]  = mk(0, 8'h5A, 1, 0, 0,  1, 0, 8'h00, 0, 0, 8'h00);
    vecs[1]  = mk(1, 8'h00, 0, 0, 0,  0, 1, 8'h5A, 0, 0, 8'h00);
    vecs[2]  = mk(1, 8'h00, 1, 0, 0,  0, 0, 8'h00, 0, 0, 8'h00);
    vecs[3]  = mk(1, 8'h00, 0, 0, 0,  0, 1, 8'h00, 1, 0, 8'h00);
    vecs[4]  = mk(0, 8'h11, 1, 1, 0,  1, 0, 8'h00, 0, 0, 8'h00);
    vecs[5]  = mk(0, 8'h22, 0, 1, 0,  0, 0, 8'h00, 0, 1, 8'h11);
    vecs[6]  = mk(0, 8'h22, 0, 1, 1,  0, 0, 8'h00, 0, 1, 8'h11);
    vecs[7]  = mk(0, 8'h22, 0, 1, 0,  1, 0, 8'h00, 0, 0, 8'h00);
    vecs[8]  = mk(1, 8'h00, 0, 1, 0,  0, 1, 8'h22, 0, 0, 8'h00);
    vecs[9]  = mk(0, 8'h33, 0, 1, 0,  1, 0, 8'h00, 0, 0, 8'h00);
    vecs[10] = mk(0, 8'h44, 0, 0, 0,  0, 0, 8'h00, 0, 1, 8'h33);
    vecs[11] = mk(0, 8'h44, 0, 0, 1,  0, 0, 8'h00, 0, 1, 8'h33);
    vecs[12] = mk(0, 8'h44, 0, 0, 0,  0, 0, 8'h00, 0, 0, 8'h00);
    vecs[13] = mk(0, 8'h44, 1, 0, 0,  1, 0, 8'h00, 0, 0, 8'h00);
    vecs[14] = mk(0, 8'h55, 1, 0, 0,  0, 1, 8'h44, 0, 0, 8'h00);
    vecs[15] = mk(0, 8'h55, 0, 0, 0,  1, 0, 8'h00, 0, 0, 8'h00);
    vecs[16] = mk(1, 8'h00, 0, 0, 0,  0, 1, 8'h55, 0, 0, 8'h00);
    vecs[17] = mk(1, 8'h00, 0, 0, 0,  0, 0, 8'h00, 0, 0, 8'h00);

    rst_n        = 1'b0;
    i_fifo_wr_en = 1'b0;
    i_timeout    = '0;
    i_irq_clr    = 1'b0;
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    do_reset("reset_state");

    // Table: CPU read, empty read, round-robin, stream hold, stream disable,
    // pend while busy.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].empty, vecs[i].data, vecs[i].req, vecs[i].sen, vecs[i].rdy);
      check($sformatf("vec%0d", i), outs(),
            pk(vecs[i].rd_en, vecs[i].cv, vecs[i].cd, vecs[i].ce, vecs[i].mv, vecs[i].md, 1'b0));
      tick();
    end

    // Alternation with CPU requesting every cycle; first grant after reset is CPU.
    do_reset("rr_reset");
    drive(0, 8'h11, 1, 1, 0); check("rr_c0_cpu_pop", outs(), pk(1, 0, 8'h00, 0, 0, 8'h00, 0)); tick();
    drive(0, 8'h22, 1, 1, 0); check("rr_c1_cpu_resp", outs(), pk(0, 1, 8'h11, 0, 0, 8'h00, 0)); tick();
    drive(0, 8'h22, 1, 1, 0); check("rr_c2_strm_pop", outs(), pk(1, 0, 8'h00, 0, 0, 8'h00, 0)); tick();
    drive(0, 8'h33, 1, 1, 1); check("rr_c3_strm_hs", outs(), pk(0, 0, 8'h00, 0, 1, 8'h22, 0)); tick();
    drive(0, 8'h33, 1, 1, 0); check("rr_c4_cpu_pop", outs(), pk(1, 0, 8'h00, 0, 0, 8'h00, 0)); tick();
    drive(1, 8'h00, 0, 0, 0); check("rr_c5_cpu_resp", outs(), pk(0, 1, 8'h33, 0, 0, 8'h00, 0)); tick();

    // Stream stalled 10 cycles, CPU request parked at stall cycle 3.
    do_reset("stall_reset");
    drive(0, 8'hA5, 0, 1, 0); check("stall_pop", outs(), pk(1, 0, 8'h00, 0, 0, 8'h00, 0)); tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 8'h77, (i == 3), 1, 0);
      check($sformatf("stall_hold%0d", i), outs(), pk(0, 0, 8'h00, 0, 1, 8'hA5, 0));
      tick();
    end
    drive(0, 8'h77, 0, 1, 1); check("stall_hs", outs(), pk(0, 0, 8'h00, 0, 1, 8'hA5, 0)); tick();
    drive(0, 8'h77, 0, 1, 0); check("stall_cpu_pop", outs(), pk(1, 0, 8'h00, 0, 0, 8'h00, 0)); tick();
    drive(1, 8'h00, 0, 0, 0); check("stall_cpu_resp", outs(), pk(0, 1, 8'h77, 0, 0, 8'h00, 0)); tick();

    // Reset in the middle of a stream hold.
    do_reset("mid_reset_pre");
    drive(0, 8'hA5, 0, 1, 0); check("mid_pop", outs(), pk(1, 0, 8'h00, 0, 0, 8'h00, 0)); tick();
    drive(0, 8'h66, 0, 1, 0); check("mid_hold", outs(), pk(0, 0, 8'h00, 0, 1, 8'hA5, 0)); tick();
    do_reset("mid_reset");
    drive(0, 8'h66, 0, 0, 0); check("mid_after", outs(), pk(0, 0, 8'h00, 0, 0, 8'h00, 0)); tick();
    drive(0, 8'h66, 1, 1, 0); check("mid_grant", outs(), pk(1, 0, 8'h00, 0, 0, 8'h00, 0)); tick();
    drive(1, 8'h00, 0, 0, 0); check("mid_cpu_first", outs(), pk(0, 1, 8'h66, 0, 0, 8'h00, 0)); tick();

    // Idle timeout: threshold 100, one write, then idle with data unread.
    do_reset("tmo_reset");
    i_timeout    = TMO_W'(100);
    i_fifo_wr_en = 1'b1;
    drive(1, 8'h00, 0, 0, 0);
    tick();
    i_fifo_wr_en = 1'b0;
    for (int k = 0; k <= 100; k++) begin
      drive(0, 8'h42, 0, 0, 0);
      if (k == 100) check_bit("tmo_before", o_irq_timeout, 1'b0);
      tick();
    end
    drive(0, 8'h42, 0, 0, 0);
    check_bit("tmo_rise", o_irq_timeout, TMO_ON);
    tick();
    check_bit("tmo_sticky", o_irq_timeout, TMO_ON);
    i_irq_clr = 1'b1;
    tick();
    i_irq_clr = 1'b0;
    #1;
    check_bit("tmo_cleared", o_irq_timeout, 1'b0);

    // Zero threshold never fires.
    begin
      logic seen;
      seen         = 1'b0;
      i_timeout    = '0;
      i_fifo_wr_en = 1'b1;
      tick();
      i_fifo_wr_en = 1'b0;
      for (int k = 0; k < 150; k++) begin
        drive(0, 8'h42, 0, 0, 0);
        seen = seen | o_irq_timeout;
        tick();
      end
      check_bit("tmo_zero_off", seen, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
